// File: rtl/hilo_pkg.sv
// Shared constants and state encoding for the HI/LO sequential multiplier.
package hilo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int PROD_WIDTH = 2 * DEF_WIDTH;

    localparam logic [5:0] MULTU_OP = 6'd1;
    localparam logic [5:0] MADDU_OP = 6'd28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mulState_t;

    function automatic logic isMulOp(input logic [5:0] opCode);
        return (opCode == MULTU_OP) || (opCode == MADDU_OP);
    endfunction

endpackage

// File: rtl/hilo_mul_step.sv
// One combinational add-and-shift iteration of the multiplier.
// HILO_MUL_RADIX4_EN selects a 2-bit-per-step variant using a precomputed 3A.
module hilo_mul_step
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
`ifdef HILO_MUL_RADIX4_EN
    input  logic [WIDTH+1:0]   mcand3,
`endif
    output logic [2*WIDTH-1:0] accNext
);

`ifdef HILO_MUL_RADIX4_EN
    logic [WIDTH+1:0] addend;
    logic [WIDTH+1:0] sum;

    // The two guard bits hold the carry of hi + 3A so the shift stays exact.
    always_comb begin
        addend = '0;
        case (acc[1:0])
            2'd0:    addend = '0;
            2'd1:    addend = {2'b00, mcand};
            2'd2:    addend = {1'b0, mcand, 1'b0};
            default: addend = mcand3;
        endcase
        sum     = {2'b00, acc[2*WIDTH-1:WIDTH]} + addend;
        accNext = {sum, acc[WIDTH-1:2]};
    end
`else
    logic [WIDTH:0] sum;

    // The carry bit is shifted back into the top of the accumulator.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        accNext = {sum, acc[WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/hilo_mul_seq.sv
// Iterative unsigned multiplier feeding the HI/LO block for MULTU/MADDU.
// Define HILO_MUL_RADIX4_EN to retire two multiplier bits per cycle.
module hilo_mul_seq
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               busy,
    output logic               done,
    output logic [5:0]         op_out,
    output logic [2*WIDTH-1:0] MulAns
);

`ifdef HILO_MUL_RADIX4_EN
    localparam int STEPS = WIDTH / 2;
`else
    localparam int STEPS = WIDTH;
`endif
    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    mulState_t          state;
    mulState_t          nextState;
    logic               accept;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic [5:0]         opHold;
`ifdef HILO_MUL_RADIX4_EN
    logic [WIDTH+1:0]   mcand3;
`endif

    assign accept = (state == IDLE) && start && isMulOp(op);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    hilo_mul_step #(.WIDTH(WIDTH)) uStep (
        .acc     (acc),
        .mcand   (mcand),
`ifdef HILO_MUL_RADIX4_EN
        .mcand3  (mcand3),
`endif
        .accNext (accNext)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = RUN;
            RUN:     if (count == LAST) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The op code is parked in opHold so op_out only moves together with MulAns.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= '0;
            mcand  <= '0;
            acc    <= '0;
            opHold <= '0;
            op_out <= '0;
            MulAns <= '0;
`ifdef HILO_MUL_RADIX4_EN
            mcand3 <= '0;
`endif
        end else if (accept) begin
            count  <= '0;
            mcand  <= src_a;
            acc    <= {{WIDTH{1'b0}}, src_b};
            opHold <= op;
`ifdef HILO_MUL_RADIX4_EN
            mcand3 <= {2'b00, src_a} + {1'b0, src_a, 1'b0};
`endif
        end else if (state == RUN) begin
            acc   <= accNext;
            count <= count + 1'b1;
            if (count == LAST) begin
                MulAns <= accNext;
                op_out <= opHold;
            end
        end
    end

endmodule

// File: tb/tb_hilo_mul_seq.sv
// Directed self-checking bench for hilo_mul_seq (latency follows HILO_MUL_RADIX4_EN).
module tb_hilo_mul_seq;

`ifdef HILO_MUL_RADIX4_EN
    localparam int LATENCY = 17;
`else
    localparam int LATENCY = 33;
`endif
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [5:0]  op_out;
    logic [63:0] MulAns;

    int compared   = 0;
    int mismatched = 0;

    hilo_mul_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .op_out (op_out),
        .MulAns (MulAns)
    );

    always #5 clk = ~clk;

    // Drives start for exactly one edge; returns sampled just after that edge.
    task automatic issueOp(input logic [31:0] a, input logic [31:0] b, input logic [5:0] code);
        start = 1'b1;
        src_a = a;
        src_b = b;
        op    = code;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the accepting edge until done, bounded by TIMEOUT.
    task automatic waitDone(output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < TIMEOUT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        op    = 6'd1;
        src_a = 32'd3;
        src_b = 32'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            compared += 4;
            if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy cyc%0d got %b want 0", i, busy); end
            if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done cyc%0d got %b want 0", i, done); end
            if (MulAns !== 64'd0) begin mismatched++; $display("[TB] FAIL reset_mulans cyc%0d got %h want 0", i, MulAns); end
            if (op_out !== 6'd0) begin mismatched++; $display("[TB] FAIL reset_opout cyc%0d got %0d want 0", i, op_out); end
        end
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int cycles;
        issueOp(32'd3, 32'd5, 6'd1);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
        waitDone(cycles);
        compared += 3;
        if (cycles !== LATENCY) begin mismatched++; $display("[TB] FAIL basic_latency got %0d want %0d", cycles, LATENCY); end
        if (MulAns !== 64'h0000_0000_0000_000F) begin mismatched++; $display("[TB] FAIL basic_mulans got %h want f", MulAns); end
        if (op_out !== 6'd1) begin mismatched++; $display("[TB] FAIL basic_opout got %0d want 1", op_out); end
        @(posedge clk);
        #1;
        compared += 3;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_done_pulse got %b want 0", done); end
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_busy_drop got %b want 0", busy); end
        if (MulAns !== 64'h0000_0000_0000_000F) begin mismatched++; $display("[TB] FAIL basic_hold got %h want f", MulAns); end
    endtask

    task automatic test_max();
        int cycles;
        issueOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd28);
        waitDone(cycles);
        compared += 3;
        if (cycles !== LATENCY) begin mismatched++; $display("[TB] FAIL max_latency got %0d want %0d", cycles, LATENCY); end
        if (MulAns !== 64'hFFFF_FFFE_0000_0001) begin mismatched++; $display("[TB] FAIL max_mulans got %h want fffffffe00000001", MulAns); end
        if (op_out !== 6'd28) begin mismatched++; $display("[TB] FAIL max_opout got %0d want 28", op_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        int cycles;
        issueOp(32'd0, 32'hDEAD_BEEF, 6'd1);
        waitDone(cycles);
        compared += 2;
        if (cycles !== LATENCY) begin mismatched++; $display("[TB] FAIL zero_latency got %0d want %0d", cycles, LATENCY); end
        if (MulAns !== 64'd0) begin mismatched++; $display("[TB] FAIL zero_a_mulans got %h want 0", MulAns); end
        @(posedge clk);
        #1;
        issueOp(32'h1234_5678, 32'd0, 6'd28);
        waitDone(cycles);
        compared += 2;
        if (MulAns !== 64'd0) begin mismatched++; $display("[TB] FAIL zero_b_mulans got %h want 0", MulAns); end
        if (op_out !== 6'd28) begin mismatched++; $display("[TB] FAIL zero_b_opout got %0d want 28", op_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_op();
        int busySeen = 0;
        int doneSeen = 0;
        issueOp(32'd9, 32'd9, 6'd5);
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b0) busySeen++;
            if (done !== 1'b0) doneSeen++;
            @(posedge clk);
            #1;
        end
        compared += 3;
        if (busySeen !== 0) begin mismatched++; $display("[TB] FAIL badop_busy got %0d cycles want 0", busySeen); end
        if (doneSeen !== 0) begin mismatched++; $display("[TB] FAIL badop_done got %0d pulses want 0", doneSeen); end
        if (MulAns !== 64'd0) begin mismatched++; $display("[TB] FAIL badop_hold got %h want 0", MulAns); end
    endtask

    task automatic test_ignore_midrun();
        int doneSeen = 0;
        issueOp(32'd2, 32'd3, 6'd1);
        for (int i = 1; i <= 60; i++) begin
            if (i == 5) begin
                start = 1'b1;
                src_a = 32'd7;
                src_b = 32'd7;
                op    = 6'd28;
            end else if (i == 6) begin
                start = 1'b0;
            end
            if (done === 1'b1) doneSeen++;
            @(posedge clk);
            #1;
        end
        compared += 3;
        if (doneSeen !== 1) begin mismatched++; $display("[TB] FAIL midrun_done_count got %0d want 1", doneSeen); end
        if (MulAns !== 64'd6) begin mismatched++; $display("[TB] FAIL midrun_mulans got %h want 6", MulAns); end
        if (op_out !== 6'd1) begin mismatched++; $display("[TB] FAIL midrun_opout got %0d want 1", op_out); end
    endtask

    task automatic test_reset_midrun();
        int doneSeen = 0;
        int cycles;
        issueOp(32'd11, 32'd13, 6'd28);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        compared += 4;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_done got %b want 0", done); end
        if (MulAns !== 64'd0) begin mismatched++; $display("[TB] FAIL rstmid_mulans got %h want 0", MulAns); end
        if (op_out !== 6'd0) begin mismatched++; $display("[TB] FAIL rstmid_opout got %0d want 0", op_out); end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) doneSeen++;
            @(posedge clk);
            #1;
        end
        compared++;
        if (doneSeen !== 0) begin mismatched++; $display("[TB] FAIL rstmid_no_done got %0d want 0", doneSeen); end
        issueOp(32'h0001_0000, 32'h0001_0000, 6'd1);
        waitDone(cycles);
        compared += 2;
        if (cycles !== LATENCY) begin mismatched++; $display("[TB] FAIL rstmid_restart_latency got %0d want %0d", cycles, LATENCY); end
        if (MulAns !== 64'h0000_0001_0000_0000) begin mismatched++; $display("[TB] FAIL rstmid_restart_mulans got %h want 100000000", MulAns); end
        @(posedge clk);
        #1;
    endtask

    // Each op is issued in the IDLE cycle right after done; MulAns must hold meanwhile.
    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expected;
        logic [63:0] prev;
        int cycles;
        prev = MulAns;
        for (int n = 0; n < 200; n++) begin
            a = $urandom();
            b = $urandom();
            if (n == 0) a = 32'hFFFF_FFFF;
            expected = 64'(a) * 64'(b);
            issueOp(a, b, (n % 2 == 0) ? 6'd1 : 6'd28);
            cycles = 1;
            while (done !== 1'b1 && cycles < TIMEOUT) begin
                compared++;
                if (MulAns !== prev) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_hold op%0d got %h want %h", n, MulAns, prev);
                end
                @(posedge clk);
                #1;
                cycles++;
            end
            compared += 2;
            if (cycles !== LATENCY) begin mismatched++; $display("[TB] FAIL b2b_latency op%0d got %0d want %0d", n, cycles, LATENCY); end
            if (MulAns !== expected) begin mismatched++; $display("[TB] FAIL b2b_mulans op%0d a=%h b=%h got %h want %h", n, a, b, MulAns, expected); end
            prev = expected;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op    = 6'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        test_reset();
        test_ignore_op();
        test_basic();
        test_max();
        test_zero();
        test_ignore_midrun();
        test_reset_midrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
